// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared constants and helpers for the programmable sequence detector.
//   DEF_PAT / DEF_LEN : pattern loaded at reset (10110, five bits, LSB-aligned)
//   calc_len_w        : width needed to hold a length value 0..max_len
//   sat_inc           : increment that sticks at max_val
package seq_det_pkg;

    localparam logic [7:0] DEF_PAT = 8'b0001_0110;
    localparam int         DEF_LEN = 5;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int unsigned sat_inc(input int unsigned val,
                                            input int unsigned max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// seq_match_cmp
// Combinational match check of the post-shift history against the active
// pattern over the low len_i bits.
//   hist_i  : history including the bit being sampled (newest bit in bit 0)
//   pat_i   : active pattern, LSB-aligned
//   len_i   : active pattern length (1..MAX_LEN)
//   fill_i  : number of eligible bits held after this sample
//   match_o : enough eligible bits and the low len_i bits agree
module seq_match_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] hist_i,
    input  logic [MAX_LEN-1:0] pat_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [LEN_W-1:0]   fill_i,
    output logic               match_o
);

    logic [MAX_LEN-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end
        match_o = (fill_i >= len_i) && (((hist_i ^ pat_i) & mask) == '0);
    end

endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector
// Runtime-programmable serial sequence detector with saturating match count.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   data_i, valid_i  : serial bit and its qualifier
//   overlap_i        : 1 = matched bits may start the next match
//   pat_load_i       : load pat_in_i / len_in_i (wins over valid_i)
//   pat_in_i, len_in_i : new pattern (bit len-1 received first) and length
//   cnt_clr_i        : clear match counter (a same-cycle match leaves 1)
//   detected_o       : one-cycle pulse after the final pattern bit is sampled
//   match_count_o    : saturating match count
//   load_err_o       : one-cycle pulse on a rejected load
//   cur_len_o        : active pattern length
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(seq_det_pkg::DEF_PAT),
    parameter int                 DEF_LEN = seq_det_pkg::DEF_LEN,
    parameter int                 LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               data_i,
    input  logic               valid_i,
    input  logic               overlap_i,
    input  logic               pat_load_i,
    input  logic [MAX_LEN-1:0] pat_in_i,
    input  logic [LEN_W-1:0]   len_in_i,
    input  logic               cnt_clr_i,
    output logic               detected_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic               load_err_o,
    output logic [LEN_W-1:0]   cur_len_o
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    // Only MAX_LEN-1 past bits are stored: together with the incoming bit
    // they form the full MAX_LEN-bit window used for comparison.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic               hit;
    logic               len_ok;
    logic [MAX_LEN-1:0] load_mask;
    logic [CNT_W-1:0]   cnt_base;

    assign hist_n = {hist_q, data_i};
    assign fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign len_ok = (len_in_i != '0) && (len_in_i <= LEN_W'(MAX_LEN));

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist_i  (hist_n),
        .pat_i   (pat_q),
        .len_i   (len_q),
        .fill_i  (fill_n),
        .match_o (hit)
    );

    always_comb begin
        load_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            load_mask[i] = (LEN_W'(i) < len_in_i);
        end
    end

    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        det_d    = 1'b0;
        err_d    = 1'b0;
        // Clear applies first so a coincident match leaves the counter at 1.
        cnt_base = cnt_clr_i ? '0 : cnt_q;
        cnt_d    = cnt_base;

        if (pat_load_i) begin
            if (len_ok) begin
                pat_d  = pat_in_i & load_mask;
                len_d  = len_in_i;
                hist_d = '0;
                fill_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (valid_i) begin
            hist_d = hist_n[MAX_LEN-2:0];
            // Non-overlapping mode discards every bit of a completed match.
            fill_d = (hit && !overlap_i) ? '0 : fill_n;
            det_d  = hit;
            if (hit) begin
                cnt_d = CNT_W'(sat_inc(32'(cnt_base), CNT_MAX));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign detected_o    = det_q;
    assign load_err_o    = err_q;
    assign match_count_o = cnt_q;
    assign cur_len_o     = len_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector
// Scoreboard bench: each driven cycle runs a queue-of-bits reference model
// and pushes the expected outputs; they are popped and compared just after
// the clock edge that produces them. Scenario-level checks use constants.
module tb_param_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       data;
    logic       valid;
    logic       overlap;
    logic       pat_load;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       cnt_clr;
    logic       detected;
    logic [3:0] match_count;
    logic       load_err;
    logic [3:0] cur_len;

    always #5 clk = ~clk;

    param_seq_detector #(
        .MAX_LEN (8),
        .CNT_W   (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_i        (data),
        .valid_i       (valid),
        .overlap_i     (overlap),
        .pat_load_i    (pat_load),
        .pat_in_i      (pat_in),
        .len_in_i      (len_in),
        .cnt_clr_i     (cnt_clr),
        .detected_o    (detected),
        .match_count_o (match_count),
        .load_err_o    (load_err),
        .cur_len_o     (cur_len)
    );

    typedef struct packed {
        logic       det;
        logic       err;
        logic [3:0] cnt;
        logic [3:0] len;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pulse_vec;

    logic [7:0]  m_pat;
    int          m_len;
    bit          m_bits[$];
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic d, input logic v, input logic ov,
                              input logic pl, input logic [7:0] pi, input logic [3:0] li,
                              input logic cc);
        exp_t e;
        bit   match;
        match = 1'b0;
        e     = '0;
        if (r) begin
            m_pat = 8'b0001_0110;
            m_len = 5;
            m_bits.delete();
            m_cnt = 0;
        end else begin
            if (cc) m_cnt = 0;
            if (pl) begin
                if (li >= 1 && li <= 8) begin
                    m_pat = '0;
                    for (int k = 0; k < int'(li); k++) m_pat[k] = pi[k];
                    m_len = int'(li);
                    m_bits.delete();
                end else begin
                    e.err = 1'b1;
                end
            end else if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() > 8) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len) begin
                    match = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k])
                            match = 1'b0;
                end
                if (match) begin
                    if (m_cnt < 15) m_cnt++;
                    if (!ov) m_bits.delete();
                end
                e.det = match;
            end
        end
        e.cnt = m_cnt[3:0];
        e.len = m_len[3:0];
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic d, input logic v, input logic ov,
                        input logic pl, input logic [7:0] pi, input logic [3:0] li,
                        input logic cc);
        exp_t e;
        rst = r; data = d; valid = v; overlap = ov;
        pat_load = pl; pat_in = pi; len_in = li; cnt_clr = cc;
        @(posedge clk);
        model_step(r, d, v, ov, pl, pi, li, cc);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("detected", 32'(detected), 32'(e.det));
            chk("load_err", 32'(load_err), 32'(e.err));
            chk("match_count", 32'(match_count), 32'(e.cnt));
            chk("cur_len", 32'(cur_len), 32'(e.len));
        end
        pulse_vec = {pulse_vec[30:0], detected};
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic bit_in(input logic d, input logic ov);
        step(1'b0, d, 1'b1, ov, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic idle(input logic cc);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, cc);
    endtask

    task automatic load(input logic [7:0] pi, input logic [3:0] li);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pi, li, 1'b0);
    endtask

    // bits[n-1] is sent first
    task automatic stream(input logic [31:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i], ov);
    endtask

    initial begin
        pulse_vec = '0;
        do_rst();
        do_rst();
        chk("rst_count", 32'(match_count), 32'd0);
        chk("rst_len", 32'(cur_len), 32'd5);

        // default pattern, overlapping
        pulse_vec = '0;
        stream(32'b1011_0110, 8, 1'b1);
        chk("t1_pulses", pulse_vec[7:0], 32'b0000_1001);
        chk("t1_count", 32'(match_count), 32'd2);

        // default pattern, non-overlapping
        do_rst();
        pulse_vec = '0;
        stream(32'b1011_0110, 8, 1'b0);
        chk("t2_pulses", pulse_vec[7:0], 32'b0000_1000);
        chk("t2_count", 32'(match_count), 32'd1);

        // 111 pattern, overlapping
        load(8'b0000_0111, 4'd3);
        chk("t3_len", 32'(cur_len), 32'd3);
        idle(1'b1);
        pulse_vec = '0;
        stream(32'b11111, 5, 1'b1);
        chk("t3_pulses", pulse_vec[4:0], 32'b00111);
        chk("t3_count", 32'(match_count), 32'd3);

        // 111 pattern, non-overlapping
        load(8'b0000_0111, 4'd3);
        pulse_vec = '0;
        stream(32'b11111, 5, 1'b0);
        chk("t4_pulses", pulse_vec[4:0], 32'b00100);
        chk("t4_count", 32'(match_count), 32'd4);

        // gap with valid low and data high
        do_rst();
        pulse_vec = '0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("t5_pulses", pulse_vec[5:0], 32'b000001);

        // reset mid-sequence after a 111 load
        load(8'b0000_0111, 4'd3);
        chk("t6_len3", 32'(cur_len), 32'd3);
        stream(32'b1011, 4, 1'b1);
        do_rst();
        bit_in(1'b0, 1'b1);
        chk("t6_nodet", 32'(detected), 32'd0);
        chk("t6_len5", 32'(cur_len), 32'd5);
        pulse_vec = '0;
        stream(32'b10110, 5, 1'b1);
        chk("t6_pulses", pulse_vec[4:0], 32'b00001);

        // rejected loads
        load(8'h01, 4'd0);
        chk("t7_err0", 32'(load_err), 32'd1);
        chk("t7_len", 32'(cur_len), 32'd5);
        idle(1'b0);
        chk("t7_err_pulse", 32'(load_err), 32'd0);
        load(8'h01, 4'd9);
        chk("t7_err9", 32'(load_err), 32'd1);

        // pat_load beats valid: that bit is dropped
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0011, 4'd2, 1'b0);
        bit_in(1'b1, 1'b1);
        chk("t8_drop", 32'(detected), 32'd0);
        bit_in(1'b1, 1'b1);
        chk("t8_det", 32'(detected), 32'd1);

        // saturation: 20 overlapping matches on a 4-bit counter
        load(8'b0000_0111, 4'd3);
        idle(1'b1);
        for (int i = 0; i < 22; i++) bit_in(1'b1, 1'b1);
        chk("t9_sat", 32'(match_count), 32'd15);

        // clear coincident with a match
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
        chk("t10_clr_match", 32'(match_count), 32'd1);
        chk("t10_det", 32'(detected), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Runtime-programmable serial bit-sequence detector; next generation of the fixed 10110 Moore detector.
- Pattern length and value load at runtime up to MAX_LEN bits; overlapping or non-overlapping detection selected by a mode input; input qualified by a valid strobe.
- Keeps a saturating match counter. Sits on a serial data path as a frame-marker/sync-word detector.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
DEF_PAT, 8'b0001_0110, reset pattern (LSB-aligned, 10110)
DEF_LEN, 5, reset pattern length
LEN_W, $clog2(MAX_LEN+1), width of length fields

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
data  input  1  serial data bit
valid  input  1  data qualifier; bit sampled only when high
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
pat_load  input  1  load pat_in/len_in this cycle
pat_in  input  MAX_LEN  new pattern, LSB-aligned, bit len-1 = first bit received
len_in  input  LEN_W  new pattern length
cnt_clr  input  1  clear match counter
detected  output  1  one-cycle registered match pulse
match_count  output  CNT_W  saturating count of matches
load_err  output  1  one-cycle pulse, rejected load
cur_len  output  LEN_W  active pattern length

Behaviour:
- Reset (rst=1 at posedge): pat=DEF_PAT, len=DEF_LEN, history=0, fill=0, detected=0, match_count=0, load_err=0. Reset overrides every other input, including mid-sequence and any earlier load.
- State: hist (MAX_LEN-bit shift register), fill (0..MAX_LEN, count of eligible received bits).
- Sample (valid=1, pat_load=0): hist_n={hist[MAX_LEN-2:0],data}; fill_n=min(fill+1,MAX_LEN).
- Match: fill_n>=len and hist_n[len-1:0]==pat[len-1:0]. First-received bit compares against pat[len-1] (MSB-first).
- Moore-style output: detected is registered and goes high for exactly the one cycle after the edge that samples the final pattern bit.
- On match, match_count increments, saturating at 2^CNT_W-1.
- Overlap handling on a match:
  - overlap=1: fill keeps fill_n, so the trailing bits can start the next match.
  - overlap=0: fill<=0, so no bit of a matched sequence is reused.
- overlap is read on each sample; a change takes effect at the next sampled bit.
- valid=0: hist and fill hold, detected<=0, data ignored.
- pat_load=1:
  - If 1<=len_in<=MAX_LEN: pat<=pat_in masked to len_in bits, len<=len_in, hist<=0, fill<=0, detected<=0.
  - Otherwise: pat and len are unchanged, load_err<=1 for one cycle, history is untouched.
  - pat_load beats valid in the same cycle; that data bit is dropped.
- cnt_clr=1: match_count<=0. If a match occurs in the same cycle, the result is 1 (clear then increment).
- cur_len reflects len; the new value is visible the cycle after a successful load.

Decomposition:
- Shared package seq_det_pkg: DEF_PAT/DEF_LEN constants, LEN_W computation function, saturating-increment function.
- One natural sub-module, seq_match_cmp: combinational masked compare of hist_n vs pat over len bits plus the fill>=len check.
- Top level holds the registers, load logic, counter and output registers.

Test Plan:
- Default pattern, overlap=1, valid=1, stream 1,0,1,1,0,1,1,0 -> detected pulses the cycle after bits 5 and 8; match_count=2.
- Same stream, overlap=0 -> single pulse after bit 5; match_count=1.
- Load pat_in=3'b111, len_in=3; stream 1,1,1,1,1:
  - overlap=1 -> pulses after bits 3, 4, 5.
  - overlap=0 -> pulse after bit 3 only.
- Stream 1,0,1,1,0 with a valid=0, data=1 cycle inserted after bit 2 -> still exactly one pulse, after the final sampled 0; no pulse during the gap.
- Stream 1,0,1,1, then rst=1 for one cycle, then 0 -> no detect; after a prior 3'b111 load, the pattern reverts to 10110 and cur_len=5.
- Boundary cases:
  - len_in=0 load -> load_err pulse, cur_len unchanged.
  - CNT_W=4, 20 overlapping matches -> match_count=15.
  - cnt_clr asserted with a match -> match_count=1.
